// File: rtl/rec_ack_gen.sv
// -----------------------------------------------------------------------------
// rec_ack_gen
//
// Receive side of the OTN serial link.
//  - Synchronises the asynchronous serial line and recovers bit timing with a
//    tick-driven phase counter that re-aligns on every line transition.
//  - Hunts for the 48-bit FAS (F6 F6 F6 28 28 28, sent LSB-first). On a match
//    it deserialises the rest of the frame, one LSB-first byte at a time, to
//    the demapper.
//  - With ARQ enabled it waits for the demapper's verdict after each frame.
//    It then returns a 3-bit acknowledge word (start=0, verdict, stop=0) on
//    the ACK line, which idles high.
//
// Ports
//  i_clk                in   system clock
//  i_rst                in   synchronous active-high reset
//  i_sclk_en_16_x_baud  in   tick enable; all bit timing advances on ticks only
//  i_otn_rx_data        in   serial frame data from the sender (asynchronous)
//  i_arq_en             in   1 = return an ACK after each frame (frame-end sample)
//  o_data[7:0]          out  deserialised byte, qualified by o_data_valid
//  o_data_valid         out  1-clock pulse per post-FAS byte
//  o_frame_start        out  1-clock pulse on FAS match
//  o_frame_done         out  1-clock pulse with the last byte of the frame
//  i_frame_ok_valid     in   demapper verdict strobe
//  i_frame_ok           in   verdict, 1 = good frame
//  o_otn_tx_ack         out  ACK line to the sender, idle high
//  o_ack_busy           out  high while waiting for a verdict or sending an ACK
// -----------------------------------------------------------------------------
module rec_ack_gen #(
    parameter int FRAME_BYTES = 4164,
    parameter int BIT_TICKS   = 20,
    parameter int SAMPLE_PT   = 9,
    parameter int VERDICT_TO  = 4096
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sclk_en_16_x_baud,
    input  logic       i_otn_rx_data,
    input  logic       i_arq_en,
    output logic [7:0] o_data,
    output logic       o_data_valid,
    output logic       o_frame_start,
    output logic       o_frame_done,
    input  logic       i_frame_ok_valid,
    input  logic       i_frame_ok,
    output logic       o_otn_tx_ack,
    output logic       o_ack_busy
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [1:0] ST_HUNT         = 2'd0;
    localparam logic [1:0] ST_RECV         = 2'd1;
    localparam logic [1:0] ST_WAIT_VERDICT = 2'd2;
    localparam logic [1:0] ST_SEND_ACK     = 2'd3;

    // The first byte on the line ends up in the low byte after 48 LSB-first shifts.
    localparam logic [47:0] FAS_PATTERN = 48'h282828F6F6F6;
    localparam int          FAS_BYTES   = 6;

    localparam logic [12:0] FAS_COUNT   = 13'(FAS_BYTES);
    localparam logic [12:0] FRAME_LIMIT = 13'(FRAME_BYTES);
    localparam logic [12:0] LAST_BYTE   = 13'(FRAME_BYTES - 1);

    localparam logic [4:0]  PH_LAST     = 5'(BIT_TICKS - 1);
    localparam logic [4:0]  PH_SAMPLE   = 5'(SAMPLE_PT);

    localparam int              TMR_W    = (VERDICT_TO > 2) ? $clog2(VERDICT_TO) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(VERDICT_TO - 1);

    genvar gi;

    // -------------------------------------------------------------------------
    // Input synchroniser and edge detector
    // -------------------------------------------------------------------------
    // sync_reg[0] is the metastability catcher; [1] and [2] are stable copies.
    logic [2:0] sync_reg;
    logic       line_edge;
    logic       rx_bit;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_reg <= 3'b000;
        end else begin
            sync_reg <= {sync_reg[1:0], i_otn_rx_data};
        end
    end

    assign line_edge = sync_reg[1] ^ sync_reg[2];
    assign rx_bit    = sync_reg[2];

    // -------------------------------------------------------------------------
    // Bit phase recovery
    // -------------------------------------------------------------------------
    // The phase counter restarts on any transition seen on a tick, so sender
    // clock drift is absorbed at every edge. Between edges it free-runs with
    // the nominal bit period.
    logic [4:0] ph_reg;
    logic [4:0] ph_next;
    logic       bit_strobe;

    always_comb begin
        ph_next = ph_reg;
        if (i_sclk_en_16_x_baud) begin
            if (line_edge) begin
                ph_next = 5'd0;
            end else if (ph_reg >= PH_LAST) begin
                ph_next = 5'd0;
            end else begin
                ph_next = ph_reg + 5'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ph_reg <= 5'd0;
        end else begin
            ph_reg <= ph_next;
        end
    end

    assign bit_strobe = i_sclk_en_16_x_baud && (ph_reg == PH_SAMPLE);

    // -------------------------------------------------------------------------
    // Frame / ACK state registers
    // -------------------------------------------------------------------------
    logic [1:0]       state_reg,      state_next;
    logic [47:0]      sr48_reg,       sr48_next;
    logic [7:0]       byte_sr_reg,    byte_sr_next;
    logic [2:0]       bit_cnt_reg,    bit_cnt_next;
    logic [12:0]      byte_cnt_reg,   byte_cnt_next;
    logic [TMR_W-1:0] timer_reg,      timer_next;
    logic             verdict_reg,    verdict_next;
    logic [4:0]       ack_tick_reg,   ack_tick_next;
    logic [1:0]       ack_idx_reg,    ack_idx_next;
    logic             ack_line_reg,   ack_line_next;
    logic [7:0]       data_reg,       data_next;
    logic             data_valid_reg, data_valid_next;
    logic             start_reg,      start_next;
    logic             done_reg,       done_next;

    // -------------------------------------------------------------------------
    // FAS comparator, evaluated on the value the hunt register is about to take
    // so a match is recognised on the strobe that completes the pattern.
    // -------------------------------------------------------------------------
    logic [47:0]          sr_shift;
    logic [7:0]           byte_shift;
    logic [FAS_BYTES-1:0] fas_byte_hit;
    logic                 fas_hit;

    assign sr_shift   = {rx_bit, sr48_reg[47:1]};
    assign byte_shift = {rx_bit, byte_sr_reg[7:1]};

    generate
        for (gi = 0; gi < FAS_BYTES; gi++) begin : g_fas_cmp
            assign fas_byte_hit[gi] = (sr_shift[8*gi +: 8] == FAS_PATTERN[8*gi +: 8]);
        end
    endgenerate

    assign fas_hit = &fas_byte_hit;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        sr48_next       = sr48_reg;
        byte_sr_next    = byte_sr_reg;
        bit_cnt_next    = bit_cnt_reg;
        byte_cnt_next   = byte_cnt_reg;
        timer_next      = timer_reg;
        verdict_next    = verdict_reg;
        ack_tick_next   = ack_tick_reg;
        ack_idx_next    = ack_idx_reg;
        ack_line_next   = ack_line_reg;
        data_next       = data_reg;
        data_valid_next = 1'b0;
        start_next      = 1'b0;
        done_next       = 1'b0;

        case (state_reg)
            ST_HUNT: begin
                if (bit_strobe) begin
                    sr48_next = sr_shift;
                    if (fas_hit) begin
                        start_next    = 1'b1;
                        byte_cnt_next = FAS_COUNT;
                        bit_cnt_next  = 3'd0;
                        state_next    = ST_RECV;
                    end
                end
            end

            ST_RECV: begin
                // FAS-like payload never reaches the hunt comparator here.
                if (bit_strobe) begin
                    byte_sr_next = byte_shift;
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        data_next       = byte_shift;
                        data_valid_next = 1'b1;
                        if (byte_cnt_reg < FRAME_LIMIT) begin
                            byte_cnt_next = byte_cnt_reg + 13'd1;
                        end
                        // ">=" keeps the frame terminating even if the count
                        // were ever to reach the guard value.
                        if (byte_cnt_reg >= LAST_BYTE) begin
                            done_next = 1'b1;
                            sr48_next = 48'd0;
                            if (i_arq_en) begin
                                timer_next = '0;
                                state_next = ST_WAIT_VERDICT;
                            end else begin
                                state_next = ST_HUNT;
                            end
                        end
                    end
                end
            end

            ST_WAIT_VERDICT: begin
                if (i_frame_ok_valid || (timer_reg == TMR_LAST)) begin
                    // A missing verdict is treated as a bad frame.
                    verdict_next  = i_frame_ok_valid ? i_frame_ok : 1'b0;
                    ack_tick_next = 5'd0;
                    ack_idx_next  = 2'd0;
                    ack_line_next = 1'b0;  // start bit
                    state_next    = ST_SEND_ACK;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end

            ST_SEND_ACK: begin
                if (i_sclk_en_16_x_baud) begin
                    if (ack_tick_reg >= PH_LAST) begin
                        ack_tick_next = 5'd0;
                        case (ack_idx_reg)
                            2'd0: begin
                                ack_line_next = verdict_reg;
                                ack_idx_next  = 2'd1;
                            end
                            2'd1: begin
                                ack_line_next = 1'b0;  // stop bit
                                ack_idx_next  = 2'd2;
                            end
                            default: begin
                                ack_line_next = 1'b1;
                                ack_idx_next  = 2'd0;
                                sr48_next     = 48'd0;
                                state_next    = ST_HUNT;
                            end
                        endcase
                    end else begin
                        ack_tick_next = ack_tick_reg + 5'd1;
                    end
                end
            end

            default: begin
                state_next = ST_HUNT;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg      <= ST_HUNT;
            sr48_reg       <= 48'd0;
            byte_sr_reg    <= 8'd0;
            bit_cnt_reg    <= 3'd0;
            byte_cnt_reg   <= 13'd0;
            timer_reg      <= '0;
            verdict_reg    <= 1'b0;
            ack_tick_reg   <= 5'd0;
            ack_idx_reg    <= 2'd0;
            ack_line_reg   <= 1'b1;
            data_reg       <= 8'd0;
            data_valid_reg <= 1'b0;
            start_reg      <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            sr48_reg       <= sr48_next;
            byte_sr_reg    <= byte_sr_next;
            bit_cnt_reg    <= bit_cnt_next;
            byte_cnt_reg   <= byte_cnt_next;
            timer_reg      <= timer_next;
            verdict_reg    <= verdict_next;
            ack_tick_reg   <= ack_tick_next;
            ack_idx_reg    <= ack_idx_next;
            ack_line_reg   <= ack_line_next;
            data_reg       <= data_next;
            data_valid_reg <= data_valid_next;
            start_reg      <= start_next;
            done_reg       <= done_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_data        = data_reg;
    assign o_data_valid  = data_valid_reg;
    assign o_frame_start = start_reg;
    assign o_frame_done  = done_reg;
    assign o_otn_tx_ack  = ack_line_reg;
    assign o_ack_busy    = (state_reg == ST_WAIT_VERDICT) || (state_reg == ST_SEND_ACK);

endmodule

// File: tb/tb_rec_ack_gen.sv
module tb_rec_ack_gen;

    localparam int FB  = 24;
    localparam int BT  = 20;
    localparam int SP  = 9;
    localparam int VT  = 64;
    localparam int PAY = FB - 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b1;
    logic       rx = 1'b1;
    logic       arq = 1'b0;
    logic       ok_valid = 1'b0;
    logic       ok = 1'b0;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_start;
    logic       frame_done;
    logic       ack;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tdiv = 1;
    int tick_ph = 0;
    int drift = 0;
    int start_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;

    logic [7:0] exp_q[$];

    rec_ack_gen #(
        .FRAME_BYTES(FB),
        .BIT_TICKS  (BT),
        .SAMPLE_PT  (SP),
        .VERDICT_TO (VT)
    ) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_sclk_en_16_x_baud(tick),
        .i_otn_rx_data      (rx),
        .i_arq_en           (arq),
        .o_data             (data),
        .o_data_valid       (data_valid),
        .o_frame_start      (frame_start),
        .o_frame_done       (frame_done),
        .i_frame_ok_valid   (ok_valid),
        .i_frame_ok         (ok),
        .o_otn_tx_ack       (ack),
        .o_ack_busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        tick_ph = tick_ph + 1;
        tick = ((tick_ph % tdiv) == 0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard / pulse monitor
    always @(posedge clk) begin
        #1;
        if (frame_start === 1'b1) start_cnt++;
        if (data_valid === 1'b1) begin
            check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("data_byte", 32'(data), 32'(e));
                $display("byte: got %02h expected %02h", data, e);
            end
        end
        if (frame_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            check("done_with_last_valid", 32'(data_valid), 32'd1);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_bit(input logic b, input int ticks);
        rx = b;
        repeat (ticks * tdiv) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit jitter);
        for (int i = 0; i < 8; i++) begin
            int d;
            d = 0;
            if (jitter) begin
                d = int'($urandom_range(2)) - 1;
                if (drift + d > 2 || drift + d < -2) d = 0;
                drift = drift + d;
            end
            send_bit(b[i], BT + d);
        end
    endtask

    task automatic send_frame(input logic [7:0] pre[$], input logic [7:0] pay[$],
                              input int rst_at, input bit jitter);
        logic [7:0] fas[6];
        fas = '{8'hF6, 8'hF6, 8'hF6, 8'h28, 8'h28, 8'h28};
        drift = 0;
        for (int i = 0; i < 16; i++) send_bit(1'b1, BT);
        foreach (pre[i]) send_byte(pre[i], jitter);
        for (int i = 0; i < 6; i++) send_byte(fas[i], jitter);
        for (int i = 0; i < pay.size(); i++) begin
            if (i == rst_at) begin
                check("queue_empty_at_reset", 32'(exp_q.size()), 32'd0);
                exp_q.delete();
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            if (rst_at < 0 || i < rst_at) exp_q.push_back(pay[i]);
            send_byte(pay[i], jitter);
        end
        rx = 1'b1;
    endtask

    task automatic wait_done(input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic wait_fall(input int max, output int fall_cyc);
        int n;
        n = 0;
        fall_cyc = -1;
        while (n < max) begin
            @(posedge clk);
            #1;
            if (ack === 1'b0) begin
                fall_cyc = cyc;
                break;
            end
            n++;
        end
        check("ack_fall_seen", 32'(fall_cyc >= 0), 32'd1);
    endtask

    task automatic measure_run(input logic level, input int max, output int len);
        len = 0;
        while (ack === level && len < max) begin
            len++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [7:0] none_q[$];
        logic [7:0] pre[$];
        logic [7:0] pay[$];
        int s0, d0, len, fall, dcy;
        bit saw_low;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(ack), 32'd1);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_start", 32'(frame_start), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 1: plain frame, no ARQ
        arq = 1'b0;
        pay.delete();
        for (int i = 0; i < PAY; i++) pay.push_back(8'(i));
        s0 = start_cnt; d0 = done_cnt;
        send_frame(none_q, pay, -1, 1'b0);
        wait_done(d0);
        check("t1_start", 32'(start_cnt - s0), 32'd1);
        check("t1_queue", 32'(exp_q.size()), 32'd0);
        check("t1_ack", 32'(ack), 32'd1);
        check("t1_busy", 32'(busy), 32'd0);
        // Verdict strobe outside WAIT_VERDICT is ignored
        ok = 1'b1; ok_valid = 1'b1;
        @(negedge clk);
        ok_valid = 1'b0;
        repeat (30) @(negedge clk);
        check("t1_stray_ack", 32'(ack), 32'd1);
        check("t1_stray_busy", 32'(busy), 32'd0);
        $display("test1 done");

        // 2: ARQ with good verdict 10 clocks after done; ACK timed on slower ticks
        arq = 1'b1;
        pay.delete();
        for (int i = 0; i < PAY; i++) pay.push_back(8'(i * 7 + 3));
        d0 = done_cnt;
        send_frame(none_q, pay, -1, 1'b0);
        wait_done(d0);
        tdiv = 2;
        while (cyc < done_cyc + 10) @(negedge clk);
        check("t2_busy_wait", 32'(busy), 32'd1);
        check("t2_ack_idle", 32'(ack), 32'd1);
        ok = 1'b1; ok_valid = 1'b1;
        @(negedge clk);
        ok_valid = 1'b0; ok = 1'b0;
        wait_fall(100, fall);
        measure_run(1'b0, 200, len);
        check("t2_start_len_ok", 32'(len >= 2 * BT - 1 && len <= 2 * BT), 32'd1);
        measure_run(1'b1, 200, len);
        check("t2_ack_bit_len", 32'(len), 32'(2 * BT));
        measure_run(1'b0, 200, len);
        check("t2_stop_len", 32'(len), 32'(2 * BT));
        check("t2_ack_idle_after", 32'(ack), 32'd1);
        check("t2_busy_after", 32'(busy), 32'd0);
        tdiv = 1;
        $display("test2 done");

        // 3: ARQ, no verdict -> NAK after VERDICT_TO clocks
        pay.delete();
        for (int i = 0; i < PAY; i++) pay.push_back(8'(255 - i));
        d0 = done_cnt;
        send_frame(none_q, pay, -1, 1'b0);
        wait_done(d0);
        dcy = done_cyc;
        wait_fall(VT + 100, fall);
        check("t3_nak_delay", 32'(fall - dcy), 32'(VT));
        measure_run(1'b0, 200, len);
        check("t3_nak_len", 32'(len), 32'(3 * BT));
        check("t3_busy_after", 32'(busy), 32'd0);
        $display("test3 done");

        // 3b: reset while waiting for a verdict aborts the ACK
        d0 = done_cnt;
        send_frame(none_q, pay, -1, 1'b0);
        wait_done(d0);
        repeat (5) @(negedge clk);
        check("t3b_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t3b_busy_rst", 32'(busy), 32'd0);
        saw_low = 1'b0;
        for (int i = 0; i < VT + 80; i++) begin
            @(negedge clk);
            if (ack !== 1'b1) saw_low = 1'b1;
        end
        check("t3b_no_ack", 32'(saw_low), 32'd0);
        $display("test3b done");

        // 4: junk before FAS and a full FAS inside the payload
        arq = 1'b0;
        pre.delete();
        for (int i = 0; i < 8; i++) pre.push_back(8'hA5);
        pay.delete();
        for (int i = 0; i < PAY; i++) pay.push_back(8'(i) ^ 8'h5A);
        pay[4] = 8'hF6; pay[5] = 8'hF6; pay[6] = 8'hF6;
        pay[7] = 8'h28; pay[8] = 8'h28; pay[9] = 8'h28;
        s0 = start_cnt; d0 = done_cnt;
        send_frame(pre, pay, -1, 1'b0);
        wait_done(d0);
        repeat (40) @(negedge clk);
        check("t4_one_start", 32'(start_cnt - s0), 32'd1);
        check("t4_queue", 32'(exp_q.size()), 32'd0);
        $display("test4 done");

        // 5: reset mid-frame, then a full frame
        pay.delete();
        for (int i = 0; i < PAY; i++) pay.push_back(8'(i + 16));
        s0 = start_cnt; d0 = done_cnt;
        send_frame(none_q, pay, 8, 1'b0);
        repeat (100) @(negedge clk);
        check("t5_start_before_rst", 32'(start_cnt - s0), 32'd1);
        check("t5_no_done", 32'(done_cnt - d0), 32'd0);
        s0 = start_cnt; d0 = done_cnt;
        send_frame(none_q, pay, -1, 1'b0);
        wait_done(d0);
        check("t5_start", 32'(start_cnt - s0), 32'd1);
        check("t5_queue", 32'(exp_q.size()), 32'd0);
        $display("test5 done");

        // 6: +-1 tick jitter on bit edges
        pay.delete();
        for (int i = 0; i < PAY; i++) pay.push_back(8'($urandom_range(255)));
        s0 = start_cnt; d0 = done_cnt;
        send_frame(none_q, pay, -1, 1'b1);
        wait_done(d0);
        check("t6_start", 32'(start_cnt - s0), 32'd1);
        check("t6_queue", 32'(exp_q.size()), 32'd0);
        $display("test6 done");

        repeat (10) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
